// File: rtl/serial_frame_pkg.sv
// Shared encodings and line levels for the serial frame transmitter.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: bit_done marks the last clock of each serial bit.
module serial_bit_timer #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    // With BIT_CYCLES=1 the count is pinned at zero, so bit_done stays high.
    assign bit_done = (cnt == CNT_W'(BIT_CYCLES - 1));

    // Free-running period counter, restarted by clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity,
// stop bit(s). Line idles high. Parity is enabled by SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              serial_out,
    output logic              busy
);

    localparam int unsigned IDX_W    = $clog2(DATA_W + 1);
    localparam bit          ONE_STOP = (STOP_BITS == 1);

    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shifted;
    logic [IDX_W-1:0]  bit_idx;
    logic              stop_idx;
    logic              bit_done;
    logic              last_stop;
    logic              transfer;

    assign shifted   = shift >> 1;
    assign last_stop = (state == ST_STOP) && bit_done && (ONE_STOP || stop_idx);
    // Ready in idle (outside reset) or on the final stop clock for back-to-back frames.
    assign data_ready = (reset && (state == ST_IDLE)) || last_stop;
    assign transfer   = data_valid && data_ready;

    serial_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (transfer || (state == ST_IDLE)),
        .bit_done (bit_done)
    );

`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic parity;

    // Even parity of the word as latched at acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity <= 1'b0;
        end else if (transfer) begin
            parity <= ^data_in;
        end
    end
`endif

    // Frame FSM with registered line and busy outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            serial_out <= IDLE_LEVEL;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    serial_out <= IDLE_LEVEL;
                    busy       <= 1'b0;
                    if (transfer) begin
                        state      <= ST_START;
                        shift      <= data_in;
                        bit_idx    <= '0;
                        serial_out <= START_LEVEL;
                        busy       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state      <= ST_DATA;
                        serial_out <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            state      <= ST_PARITY;
                            serial_out <= parity;
`else
                            state      <= ST_STOP;
                            stop_idx   <= 1'b0;
                            serial_out <= IDLE_LEVEL;
`endif
                        end else begin
                            shift      <= shifted;
                            bit_idx    <= bit_idx + IDX_W'(1);
                            serial_out <= shifted[0];
                        end
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_done) begin
                        state      <= ST_STOP;
                        stop_idx   <= 1'b0;
                        serial_out <= IDLE_LEVEL;
                    end
                end
`endif
                ST_STOP: begin
                    if (last_stop) begin
                        if (transfer) begin
                            state      <= ST_START;
                            shift      <= data_in;
                            bit_idx    <= '0;
                            serial_out <= START_LEVEL;
                        end else begin
                            state      <= ST_IDLE;
                            serial_out <= IDLE_LEVEL;
                            busy       <= 1'b0;
                        end
                    end else if (bit_done) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    serial_out <= IDLE_LEVEL;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: a fast instance (BIT_CYCLES=1,
// STOP_BITS=1) and a slow one (BIT_CYCLES=4, STOP_BITS=2) checked against a
// bit-list frame model.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       so_a, so_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(1), .STOP_BITS(1)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .data_in    (din),
        .data_valid (valid_a),
        .data_ready (ready_a),
        .serial_out (so_a),
        .busy       (busy_a)
    );

    serial_frame_tx #(.DATA_W(8), .BIT_CYCLES(4), .STOP_BITS(2)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .data_in    (din),
        .data_valid (valid_b),
        .data_ready (ready_b),
        .serial_out (so_b),
        .busy       (busy_b)
    );

    function automatic logic get_so(input int sel);
        return (sel != 0) ? so_b : so_a;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel != 0) ? ready_b : ready_a;
    endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel != 0) valid_b = v;
        else          valid_a = v;
    endtask

    function automatic int frame_len(input int sel);
        int bc;
        int sb;
        int p;
        bc = (sel != 0) ? 4 : 1;
        sb = (sel != 0) ? 2 : 1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        p = 1;
`else
        p = 0;
`endif
        return (1 + 8 + p + sb) * bc;
    endfunction

    // Expected line level per clock for one frame carrying w.
    task automatic build_expected(input int sel, input logic [7:0] w);
        int bc;
        int sb;
        bc = (sel != 0) ? 4 : 1;
        sb = (sel != 0) ? 2 : 1;
        exp_q.delete();
        repeat (bc) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (bc) exp_q.push_back(w[i]);
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        repeat (bc) exp_q.push_back(^w);
`endif
        repeat (sb * bc) exp_q.push_back(1'b1);
    endtask

    task automatic wait_ready(input int sel, input string name);
        int k;
        k = 0;
        while (get_ready(sel) !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (get_ready(sel) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_timeout: data_ready=%b required 1", name, get_ready(sel));
        end
    endtask

    // One frame with random valid/data noise while the frame is in flight.
    task automatic run_frame(input int sel, input logic [7:0] w, input string name);
        int  len;
        int  busy_cnt;
        logic exp_rdy;
        wait_ready(sel, name);
        build_expected(sel, w);
        len = exp_q.size();
        din = w;
        set_valid(sel, 1'b1);
        @(posedge clk); #1;
        busy_cnt = 0;
        for (int i = 0; i < len; i++) begin
            n_checks++;
            if (get_so(sel) !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s line[%0d]: serial_out=%b required %b", name, i, get_so(sel), exp_q[i]);
            end
            if (get_busy(sel) === 1'b1) busy_cnt++;
            exp_rdy = (i == len - 1);
            n_checks++;
            if (get_ready(sel) !== exp_rdy) begin
                n_fail++;
                $display("FAIL %s ready[%0d]: data_ready=%b required %b", name, i, get_ready(sel), exp_rdy);
            end
            if (i < len - 1) begin
                set_valid(sel, 1'($urandom_range(0, 1)));
                din = 8'($urandom);
            end else begin
                set_valid(sel, 1'b0);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (busy_cnt != frame_len(sel)) begin
            n_fail++;
            $display("FAIL %s busy_len: busy cycles=%0d required %0d", name, busy_cnt, frame_len(sel));
        end
        n_checks++;
        if (get_busy(sel) !== 1'b0 || get_so(sel) !== 1'b1 || get_ready(sel) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after_frame: busy=%b line=%b ready=%b required 0 1 1",
                     name, get_busy(sel), get_so(sel), get_ready(sel));
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        valid_a = 1'b1;
        valid_b = 1'b1;
        din     = 8'h5A;
        #20;
        n_checks++;
        if (so_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: line=%b busy=%b ready=%b required 1 0 0", so_a, busy_a, ready_a);
        end
        #20;
        n_checks++;
        if (so_b !== 1'b1 || busy_b !== 1'b0 || ready_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: line=%b busy=%b ready=%b required 1 0 0", so_b, busy_b, ready_b);
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        reset   = 1'b1;
        #1;
        n_checks++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: ready_a=%b ready_b=%b required 1 1", ready_a, ready_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_frame_basic();
        run_frame(0, 8'hA5, "a5_fast");
        run_frame(0, 8'h07, "07_fast");
    endtask

    task automatic test_back_to_back();
        bit  q[$];
        int  len;
        logic exp_rdy;
        wait_ready(0, "b2b");
        build_expected(0, 8'h01);
        q = exp_q;
        len = q.size();
        build_expected(0, 8'h80);
        foreach (exp_q[i]) q.push_back(exp_q[i]);
        din     = 8'h01;
        valid_a = 1'b1;
        @(posedge clk); #1;
        din = 8'h80;
        for (int c = 0; c < 2 * len; c++) begin
            exp_rdy = (c == len - 1) || (c == 2 * len - 1);
            n_checks++;
            if (so_a !== q[c] || busy_a !== 1'b1 || ready_a !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b cycle[%0d]: line=%b busy=%b ready=%b required %b 1 %b",
                         c, so_a, busy_a, ready_a, q[c], exp_rdy);
            end
            if (c == len) valid_a = 1'b0;
            @(posedge clk); #1;
        end
        repeat (3) begin
            n_checks++;
            if (so_a !== 1'b1 || busy_a !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b idle: line=%b busy=%b required 1 0", so_a, busy_a);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_slow_frame();
        run_frame(1, 8'hFF, "ff_slow");
        run_frame(1, 8'h5C, "5c_slow");
    endtask

    task automatic test_abort();
        logic [7:0] w;
        w = 8'($urandom) & 8'hFB;
        wait_ready(0, "abort");
        din     = w;
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (so_a !== w[2]) begin
            n_fail++;
            $display("FAIL abort pre: line=%b required %b", so_a, w[2]);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (so_a !== 1'b1 || busy_a !== 1'b0 || ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL abort async: line=%b busy=%b ready=%b required 1 0 0", so_a, busy_a, ready_a);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ready_a !== 1'b1 || so_a !== 1'b1) begin
            n_fail++;
            $display("FAIL abort release: ready=%b line=%b required 1 1", ready_a, so_a);
        end
        @(posedge clk); #1;
        run_frame(0, 8'h3C, "3c_after_abort");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_frame(i % 2, 8'($urandom), "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_basic();
        test_back_to_back();
        test_slow_frame();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Serial transmitter for single-bit-line FSM exercises; drives the serial stimulus stream consumed by the sequence-detecting receiver blocks.
- Accepts a parallel word through a valid/ready handshake.
- Emits an asynchronous-style frame on one line, LSB first: start bit, data bits, optional parity bit, stop bit(s).
- Line idles high.

Parameters:
- DATA_W, 8: data bits per frame (1..16).
- BIT_CYCLES, 1: clock cycles each serial bit is held (1..255).
- STOP_BITS, 1: number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- data_in  in  DATA_W  word to transmit; sampled only on handshake.
- data_valid  in  1  producer has a word on data_in.
- data_ready  out  1  block can accept a word this cycle.
- serial_out  out  1  serial line; 1 = idle/mark.
- busy  out  1  high from the cycle after acceptance until the last stop-bit cycle inclusive.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - serial_out=1, busy=0, data_ready=0 while reset is held.
  - Shift register and counters cleared.
- data_ready is registered-state-derived and is high in either case:
  - state==IDLE and not in reset, or
  - final clock of the final stop bit (enables back-to-back frames).
- Handshake: transfer occurs on posedge when data_valid && data_ready.
  - data_in is latched into the shift register at that edge.
  - data_valid without data_ready is ignored; data_in is not sampled.
- Latency: serial_out drives the start bit (0) starting the cycle after acceptance.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START on a back-to-back acceptance.
  - IDLE: serial_out=1. On transfer, go to START.
  - START: serial_out=0 for BIT_CYCLES cycles, then DATA.
  - DATA: serial_out=shift[0]; shift right every BIT_CYCLES cycles. After DATA_W bits, go to PARITY if enabled, else STOP.
  - PARITY: see Optional Feature.
  - STOP: serial_out=1 for STOP_BITS*BIT_CYCLES cycles. On the last cycle, a transfer goes to START; otherwise go to IDLE.
- Bit timer counts 0..BIT_CYCLES-1; bit_done pulses when count==BIT_CYCLES-1.
  - BIT_CYCLES=1 means bit_done is permanently high.
- Bit index counter width is clog2(DATA_W+1); no wrap beyond DATA_W.
- Frame length in cycles = (1+DATA_W+P+STOP_BITS)*BIT_CYCLES, where P=1 with parity, else 0.
- data_in changes mid-frame have no effect.
- Reset mid-frame aborts immediately: line returns high asynchronously and the partial frame is discarded.
- Reset release: first acceptance possible on the first posedge after release.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA, lasting BIT_CYCLES cycles.
  - Its bit is even parity, i.e. XOR of all data bits latched at acceptance, computed from the latched word, not the shifted copy.
- Undefined:
  - No PARITY state and no parity logic; DATA goes directly to STOP.
  - P=0 in the frame length.

Decomposition:
- Package serial_frame_pkg:
  - state encoding localparams: ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP.
  - IDLE_LEVEL=1, START_LEVEL=0.
- One natural sub-module: serial_bit_timer (parameter BIT_CYCLES; ports clk, reset, clear, bit_done).
- FSM, shift register and bit index stay in serial_frame_tx.

Test Plan:
1. Reset: hold reset=0 for 40 ns with data_valid=1 -> serial_out=1, busy=0, data_ready=0. After release -> data_ready=1.
2. BIT_CYCLES=1, no parity: send 0xA5 -> serial_out per cycle 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). busy high for 10 cycles, then data_ready=1.
3. Parity enabled, BIT_CYCLES=1, send 0x07 -> line 0,1,1,1,0,0,0,0,0,1(parity),1(stop).
   - Send 0xA5 -> parity bit 0.
4. Back-to-back: data_valid held high with 0x01 then 0x80 -> stop bit of frame 1 directly followed by start bit of frame 2; no idle cycle; exactly two transfers.
5. BIT_CYCLES=4, STOP_BITS=2, send 0xFF -> start low 4 cycles, line high 40 cycles, total frame 44 cycles.
   - data_valid during DATA is ignored (data_ready=0).
6. Mid-frame abort: reset=0 during the 3rd data bit -> serial_out=1 immediately (before next edge).
   - After release, send 0x3C -> complete correct frame, no residue of the aborted word.
